// File: rtl/cpu_sys_cnt_ctrl.sv
// System counter with prescaler, register access, tear-free 32-bit reads
// and NUM_CMP compare channels raising level interrupts.
module cpu_sys_cnt_ctrl #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned NUM_CMP = 2
) (
    input  logic               cpu_clk,
    input  logic               pg_reset_b,
    input  logic               dbg_halt,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [4:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic [CNT_W-1:0]   sys_cnt,
    output logic [NUM_CMP-1:0] cmp_irq
);

    localparam int unsigned HI_W = CNT_W - 32;
    localparam logic [4:0] A_CTRL   = 5'd0;
    localparam logic [4:0] A_CNT_LO = 5'd1;
    localparam logic [4:0] A_CNT_HI = 5'd2;

    logic                 r_en;
    logic                 r_dbg_stop;
    logic [PRESC_W-1:0]   r_presc;
    logic [NUM_CMP-1:0]   r_ie;
    logic [PRESC_W-1:0]   r_pcnt;
    logic [CNT_W-1:0]     r_cnt;
    logic [HI_W-1:0]      r_hi_shadow;
    logic [CNT_W-1:0]     r_cmp [NUM_CMP];
    logic [31:0]          r_rdata;
    logic [NUM_CMP-1:0]   r_irq;

    logic                 w_run;
    logic                 w_tick;
    logic                 w_wr_ctrl;
    logic                 w_wr_lo;
    logic                 w_wr_hi;
    logic [NUM_CMP-1:0]   w_wr_cmp_lo;
    logic [NUM_CMP-1:0]   w_wr_cmp_hi;
    logic [NUM_CMP-1:0]   w_hit;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [31:0]          w_rdata;

    assign w_run     = r_en & ~(r_dbg_stop & dbg_halt);
    assign w_tick    = w_run & (r_pcnt == r_presc);
    assign w_wr_ctrl = reg_wr & (reg_addr == A_CTRL);
    assign w_wr_lo   = reg_wr & (reg_addr == A_CNT_LO);
    assign w_wr_hi   = reg_wr & (reg_addr == A_CNT_HI);
    assign w_cnt_inc = r_cnt + CNT_W'(w_tick);

    // A written half overrides the increment; writing HI also drops any LO carry.
    always_comb begin
        w_cnt_nxt = w_cnt_inc;
        if (w_wr_lo) w_cnt_nxt[31:0]       = reg_wdata;
        if (w_wr_hi) w_cnt_nxt[CNT_W-1:32] = reg_wdata[HI_W-1:0];
    end

    always_comb begin
        w_wr_cmp_lo = '0;
        w_wr_cmp_hi = '0;
        w_hit       = '0;
        for (int unsigned i = 0; i < NUM_CMP; i++) begin
            w_wr_cmp_lo[i] = reg_wr && (reg_addr == 5'(4 + 2 * i));
            w_wr_cmp_hi[i] = reg_wr && (reg_addr == 5'(5 + 2 * i));
            w_hit[i]       = (r_cnt >= r_cmp[i]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (reg_addr)
            A_CTRL: begin
                w_rdata[0]               = r_en;
                w_rdata[1]               = r_dbg_stop;
                w_rdata[8 +: PRESC_W]    = r_presc;
                w_rdata[16 +: NUM_CMP]   = r_ie;
            end
            A_CNT_LO: w_rdata = r_cnt[31:0];
            A_CNT_HI: w_rdata = 32'(r_hi_shadow);
            default: begin
                for (int unsigned i = 0; i < NUM_CMP; i++) begin
                    if (reg_addr == 5'(4 + 2 * i)) w_rdata = r_cmp[i][31:0];
                    if (reg_addr == 5'(5 + 2 * i)) w_rdata = 32'(r_cmp[i][CNT_W-1:32]);
                end
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            r_en        <= 1'b1;
            r_dbg_stop  <= 1'b0;
            r_presc     <= '0;
            r_ie        <= '0;
            r_pcnt      <= '0;
            r_cnt       <= '0;
            r_hi_shadow <= '0;
            r_rdata     <= '0;
            r_irq       <= '0;
            for (int unsigned i = 0; i < NUM_CMP; i++) r_cmp[i] <= '1;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= reg_wdata[0];
                r_dbg_stop <= reg_wdata[1];
                r_presc    <= reg_wdata[8 +: PRESC_W];
                r_ie       <= reg_wdata[16 +: NUM_CMP];
                r_pcnt     <= '0;
            end else if (w_run) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
            end

            r_cnt <= w_cnt_nxt;

            if (reg_rd) begin
                r_rdata <= w_rdata;
                if (reg_addr == A_CNT_LO) r_hi_shadow <= r_cnt[CNT_W-1:32];
            end

            for (int unsigned i = 0; i < NUM_CMP; i++) begin
                if (w_wr_cmp_lo[i]) r_cmp[i][31:0]       <= reg_wdata;
                if (w_wr_cmp_hi[i]) r_cmp[i][CNT_W-1:32] <= reg_wdata[HI_W-1:0];
            end

            r_irq <= r_ie & w_hit;
        end
    end

    assign reg_rdata = r_rdata;
    assign sys_cnt   = r_cnt;
    assign cmp_irq   = r_irq;

endmodule

// File: doc/cpu_sys_cnt_ctrl.md
# cpu_sys_cnt_ctrl

Parametrised system-counter and compare-timer block for the CPU subsystem. It replaces the fixed 64-bit free-running `pad_cpu_sys_cnt` incrementer. It adds:
- a configurable width and prescaler,
- software read/write access through a simple register port,
- tear-free 32-bit reads,
- `NUM_CMP` compare channels that drive level interrupts into `pad_vic_int_vld`.

It sits beside the core in the CPU subsystem wrapper and feeds the core's system-counter input directly.

## Interface
Parameters:
- `CNT_W`, 64, counter width; legal range 33..64.
- `PRESC_W`, 8, prescaler width; legal range 1..8.
- `NUM_CMP`, 2, number of compare channels; legal range 1..8.

Ports:
- `cpu_clk`  in  1  clock; all logic is on the rising edge.
- `pg_reset_b`  in  1  asynchronous, active-low reset.
- `dbg_halt`  in  1  core is in debug mode.
- `reg_wr`  in  1  register write strobe, one cycle.
- `reg_rd`  in  1  register read strobe, one cycle.
- `reg_addr`  in  5  word address.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data; registered.
- `sys_cnt`  out  `CNT_W`  current counter value, to the core's system-counter input.
- `cmp_irq`  out  `NUM_CMP`  per-channel level interrupt.

## Operation
Register map (word addresses):
- **0 CTRL**
  - bit0 `en`, reset 1.
  - bit1 `dbg_stop`, reset 0.
  - bits[8+PRESC_W-1:8] `presc`, reset 0.
  - bits[16+NUM_CMP-1:16] `ie`, reset 0.
  - Unimplemented bits read 0.
- **1 CNT_LO**
  - Read: returns `cnt[31:0]` and, in the same cycle, latches `cnt[CNT_W-1:32]` into `hi_shadow`.
  - Write: loads `cnt[31:0]`.
- **2 CNT_HI**
  - Read: returns `hi_shadow`, zero-extended.
  - Write: loads `cnt[CNT_W-1:32]` from `reg_wdata[CNT_W-33:0]`.
- **4+2i CMP_LO_i / 5+2i CMP_HI_i**: compare value of channel i, same split as CNT; reset all ones.
- **Unmapped addresses**: read 0; writes are ignored.

Counting:
- `run = en & ~(dbg_stop & dbg_halt)`.
- Prescaler counter `pcnt` (PRESC_W bits) increments each cycle while `run` is high.
- When `pcnt == presc`: `pcnt` returns to 0 and a `tick` is generated. The counter increments once every `presc+1` cycles; `presc=0` means every cycle.
- When `run` is low, `pcnt` and `cnt` hold.
- Any write to CTRL clears `pcnt` to 0.
- Wrap-around: `cnt` at all ones plus a tick gives 0. No flag is raised.
- A CNT_LO or CNT_HI write in the same cycle as a tick: the written half takes the written value, the other half takes its incremented value. Carry from a LO wrap into HI is suppressed when HI is being written. Software is expected to stop the counter (`en=0`) before a 2-part load.

Compare:
- `hit_i = (cnt >= cmp_i)`, unsigned, full `CNT_W` bits.
- `cmp_irq[i]` is registered: `cmp_irq[i] <= ie[i] & hit_i`.
- The interrupt is level, with no status bit. Software clears it by raising `cmp_i` above `cnt` or by clearing `ie[i]`.

## Timing
- **Reset values**: `cnt`=0, `pcnt`=0, `hi_shadow`=0, CTRL as above, all `cmp`=all ones, `reg_rdata`=0, `cmp_irq`=0, `sys_cnt`=0.
- **sys_cnt**: equals the `cnt` register; zero latency.
- **Read latency**: `reg_rdata` is valid the cycle after `reg_rd` and holds until the next `reg_rd`.
- **Write latency**: takes effect at the clock edge of `reg_wr`; the new value is visible on `sys_cnt` the next cycle.
- **Simultaneous `reg_rd` and `reg_wr`** to the same address: the read returns the pre-write value and the write is applied.
- **Interrupt latency**: `cmp_irq` rises 1 cycle after `cnt` first satisfies `>= cmp`. It falls 1 cycle after the condition or `ie` is removed.
- **Reset mid-operation**: asynchronous clear of all state; the counter restarts from 0 with `en=1` after `pg_reset_b` deasserts. This matches the legacy free-running behaviour with no software setup.

## Test plan
- **Reset**, then 10 cycles with no accesses → `sys_cnt` = 10, `cmp_irq` = 0, `reg_rdata` = 0.
- **Prescaler**: write CTRL `presc`=3, `en`=1, then run 40 cycles → `cnt` increments every 4th cycle, giving 10. Set `dbg_stop`=1 and `dbg_halt`=1 for 8 cycles → `cnt` holds.
- **Tear-free read**: stop the counter, load `cnt`=0x0000_0000_FFFF_FFFE, set `presc`=0, restart; read CNT_LO then CNT_HI across the wrap → the pair is consistent, e.g. LO=0xFFFF_FFFF then HI=0x0 (the HI latched at the LO read). A direct `sys_cnt` check shows 0x1_0000_0000 after the carry.
- **Compare**: `cmp0`=100, `ie[0]`=1 → `cmp_irq[0]` rises at the cycle after `cnt`=100. Write `cmp0`=0xFFFF_FFFF_FFFF_FFFF → it falls 1 cycle later. Channel 1 with `ie[1]`=0 stays 0.
- **Wrap**: load `cnt` = all ones with `en`=1 → next tick gives `sys_cnt`=0, and a compare interrupt with `cmp` = all ones deasserts.
- **Collision**: `reg_rd` and `reg_wr` on CMP_LO_0 in the same cycle with wdata 0x55 → `rdata` shows the old value; a subsequent read shows 0x55.
